// File: rtl/rab_lookup_arb.sv
// rab_lookup_arb: two-port round-robin arbiter in front of the shared RAB
// lookup. A granted request is held through LOOKUP (until the lookup takes it)
// and WAIT_SENT (until the downstream accept/drop completes or times out).
`timescale 1ns/1ps

module rab_lookup_arb #(
    parameter int unsigned AXI_ADDR_WIDTH = 40,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,

    input  logic                      port1_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] port1_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   port1_id_i,
    output logic                      port1_ready_o,

    input  logic                      port2_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] port2_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   port2_id_i,
    output logic                      port2_ready_o,

    output logic                      lookup_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] lookup_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   lookup_id_o,
    output logic                      lookup_sel_o,
    input  logic                      lookup_ready_i,

    input  logic                      resp_sent_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    // A zero timeout would give a zero-width counter; keep one bit and
    // gate the timeout off instead.
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WAIT_SENT
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic                      sel_q, sel_d;
    // 1 = port 1 was serviced last, 0 = port 2
    logic                      last_q, last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;

    logic                      grant1, grant2;

    // Round-robin grant: a lone requester wins; on a tie the port not
    // serviced last wins.
    always_comb begin
        grant1 = port1_valid_i & (~port2_valid_i | ~last_q);
        grant2 = port2_valid_i & (~port1_valid_i |  last_q);
    end

    // State, request capture, round-robin history and timeout registers.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            id_q      <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic, including request capture and timeout counting.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant1 | grant2) begin
                    state_d = LOOKUP;
                    addr_d  = grant1 ? port1_addr_i : port2_addr_i;
                    id_d    = grant1 ? port1_id_i   : port2_id_i;
                    sel_d   = grant1;
                end
            end
            LOOKUP: begin
                if (lookup_ready_i) begin
                    state_d = WAIT_SENT;
                    cnt_d   = '0;
                end
            end
            WAIT_SENT: begin
                // resp_sent_i takes priority over a timeout firing in the same cycle
                if (resp_sent_i) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = IDLE;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        port1_ready_o  = Rst_RBI & (state_q == IDLE) & grant1;
        port2_ready_o  = Rst_RBI & (state_q == IDLE) & grant2;
        lookup_valid_o = (state_q == LOOKUP);
        busy_o         = (state_q != IDLE);
    end

    assign lookup_addr_o = addr_q;
    assign lookup_id_o   = id_q;
    assign lookup_sel_o  = sel_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rab_lookup_arb.sv
// Testbench for rab_lookup_arb: table of single transactions plus hand-written
// sequences for back-to-back round-robin, timeout, long lookup stall and
// mid-operation reset. A second instance with the timeout disabled shares the
// stimulus and must never pulse timeout_o.
`timescale 1ns/1ps

module tb_rab_lookup_arb;

    localparam int AW = 40;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    logic [IW-1:0] i1 = '0, i2 = '0;
    logic          lk_rdy = 1'b0, resp = 1'b0;

    logic          rdy1, rdy2, lvalid, lsel, busy, tmo;
    logic [AW-1:0] laddr;
    logic [IW-1:0] lid;

    logic          z_rdy1, z_rdy2, z_lvalid, z_lsel, z_busy, z_tmo;
    logic [AW-1:0] z_laddr;
    logic [IW-1:0] z_lid;

    always #5 clk = ~clk;

    rab_lookup_arb #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .TIMEOUT_CYCLES(4)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .port1_valid_i(v1), .port1_addr_i(a1), .port1_id_i(i1), .port1_ready_o(rdy1),
        .port2_valid_i(v2), .port2_addr_i(a2), .port2_id_i(i2), .port2_ready_o(rdy2),
        .lookup_valid_o(lvalid), .lookup_addr_o(laddr), .lookup_id_o(lid),
        .lookup_sel_o(lsel), .lookup_ready_i(lk_rdy),
        .resp_sent_i(resp), .busy_o(busy), .timeout_o(tmo)
    );

    rab_lookup_arb #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .TIMEOUT_CYCLES(0)) dut_nto (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .port1_valid_i(v1), .port1_addr_i(a1), .port1_id_i(i1), .port1_ready_o(z_rdy1),
        .port2_valid_i(v2), .port2_addr_i(a2), .port2_id_i(i2), .port2_ready_o(z_rdy2),
        .lookup_valid_o(z_lvalid), .lookup_addr_o(z_laddr), .lookup_id_o(z_lid),
        .lookup_sel_o(z_lsel), .lookup_ready_i(lk_rdy),
        .resp_sent_i(resp), .busy_o(z_busy), .timeout_o(z_tmo)
    );

    int n_cmp = 0;
    int n_err = 0;
    int z_tmo_seen = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          sel;
    } exp_t;

    typedef struct {
        logic          v1, v2;
        logic [AW-1:0] a1, a2;
        logic [IW-1:0] i1, i2;
        logic          sel;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    always @(negedge clk) if (z_tmo === 1'b1) z_tmo_seen++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic sel);
        exp_t e;
        e.addr = addr;
        e.id   = id;
        e.sel  = sel;
        sb.push_back(e);
    endtask

    task automatic check_lookup(input string nm);
        exp_t e;
        chk({nm, "_lvalid"}, 64'(lvalid), 64'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb: got empty scoreboard, want pending grant", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_addr"}, 64'(laddr), 64'(e.addr));
            chk({nm, "_id"},   64'(lid),   64'(e.id));
            chk({nm, "_sel"},  64'(lsel),  64'(e.sel));
        end
    endtask

    // Called the negedge after a grant: lookup takes it immediately, resp one cycle later.
    task automatic finish_txn(input string nm);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; lk_rdy = 1'b1;
        #1;
        check_lookup(nm);
        @(negedge clk);
        lk_rdy = 1'b0; resp = 1'b1;
        #1;
        chk({nm, "_busy_ws"}, 64'(busy), 64'd1);
        chk({nm, "_lvalid_ws"}, 64'(lvalid), 64'd0);
        @(negedge clk);
        resp = 1'b0;
        #1;
        chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
        chk({nm, "_tmo_idle"}, 64'(tmo), 64'd0);
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        @(negedge clk);
        v1 = v.v1; v2 = v.v2; a1 = v.a1; a2 = v.a2; i1 = v.i1; i2 = v.i2;
        #1;
        chk({nm, "_rdy1"}, 64'(rdy1), 64'(v.sel));
        chk({nm, "_rdy2"}, 64'(rdy2), 64'(!v.sel));
        push_exp(v.sel ? v.a1 : v.a2, v.sel ? v.i1 : v.i2, v.sel);
        finish_txn(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pulses;
        vec_t sv;

        tbl[0] = '{1'b1, 1'b1, 40'h10, 40'h20, 4'd1,  4'd2,  1'b1};
        tbl[1] = '{1'b1, 1'b1, 40'h30, 40'h40, 4'd3,  4'd4,  1'b0};
        tbl[2] = '{1'b1, 1'b0, 40'h50, 40'h60, 4'd5,  4'd6,  1'b1};
        tbl[3] = '{1'b1, 1'b0, 40'h70, 40'h80, 4'd7,  4'd8,  1'b1};
        tbl[4] = '{1'b1, 1'b1, 40'h90, 40'hA0, 4'd9,  4'd10, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 40'hB0, 40'hC0, 4'd11, 4'd12, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 40'hD0, 40'hE0, 4'd13, 4'd14, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 40'h0,  40'hFF_FFFF_FFFF, 4'd0, 4'd15, 1'b0};

        // Reset values, with both requests high to show ready stays low.
        @(negedge clk);
        @(negedge clk);
        v1 = 1'b1; v2 = 1'b1;
        #1;
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_lvalid", 64'(lvalid), 64'd0);
        chk("rst_rdy1",   64'(rdy1),   64'd0);
        chk("rst_rdy2",   64'(rdy2),   64'd0);
        chk("rst_addr",   64'(laddr),  64'd0);
        chk("rst_id",     64'(lid),    64'd0);
        chk("rst_sel",    64'(lsel),   64'd0);
        chk("rst_tmo",    64'(tmo),    64'd0);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

        // Both ports held valid, minimum turnaround: accepts every 3 cycles, alternating.
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            v1 = 1'b1; v2 = 1'b1; a1 = 40'h111; a2 = 40'h222; i1 = 4'd1; i2 = 4'd2;
            lk_rdy = (k % 3 == 1);
            resp   = (k % 3 == 2);
            #1;
            chk($sformatf("rr%0d_rdy1", k), 64'(rdy1), 64'((k % 3 == 0) && ((k / 3) % 2 == 0)));
            chk($sformatf("rr%0d_rdy2", k), 64'(rdy2), 64'((k % 3 == 0) && ((k / 3) % 2 == 1)));
            if (k % 3 == 0) begin
                if ((k / 3) % 2 == 0) push_exp(40'h111, 4'd1, 1'b1);
                else                  push_exp(40'h222, 4'd2, 1'b0);
            end
            if (k % 3 == 1) check_lookup($sformatf("rr%0d", k));
        end
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; resp = 1'b0;

        // Timeout: resp never comes; one pulse in the first IDLE cycle.
        @(negedge clk);
        v1 = 1'b1; a1 = 40'hAAA; i1 = 4'd5;
        #1;
        chk("to_rdy1", 64'(rdy1), 64'd1);
        push_exp(40'hAAA, 4'd5, 1'b1);
        @(negedge clk);
        v1 = 1'b0; lk_rdy = 1'b1;
        #1;
        check_lookup("to");
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            lk_rdy = 1'b0;
            #1;
            if (tmo === 1'b1) pulses++;
            chk($sformatf("to_k%0d_tmo", k),  64'(tmo),  64'(k == 5));
            chk($sformatf("to_k%0d_busy", k), 64'(busy), 64'(k <= 4));
        end
        chk("to_pulses", 64'(pulses), 64'd1);
        // Timed-out port 1 counts as serviced, so port 2 wins the tie.
        sv = '{1'b1, 1'b1, 40'h1A, 40'h2A, 4'd3, 4'd4, 1'b0};
        do_txn(sv, "to_tie");

        // resp_sent_i on the 4th WAIT_SENT cycle beats the timeout.
        @(negedge clk);
        v2 = 1'b1; a2 = 40'hBBB; i2 = 4'd6;
        #1;
        chk("rw_rdy2", 64'(rdy2), 64'd1);
        push_exp(40'hBBB, 4'd6, 1'b0);
        @(negedge clk);
        v2 = 1'b0; lk_rdy = 1'b1;
        #1;
        check_lookup("rw");
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            lk_rdy = 1'b0;
            resp   = (k == 4);
            #1;
            chk($sformatf("rw_k%0d_tmo", k),  64'(tmo),  64'd0);
            chk($sformatf("rw_k%0d_busy", k), 64'(busy), 64'(k <= 4));
        end

        // Long lookup stall with a competing port 2 request and a stray resp_sent_i.
        @(negedge clk);
        v1 = 1'b1; a1 = 40'hCCC; i1 = 4'd7;
        #1;
        chk("st_rdy1", 64'(rdy1), 64'd1);
        push_exp(40'hCCC, 4'd7, 1'b1);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b1; a2 = 40'hDDD; i2 = 4'd8;
        #1;
        check_lookup("st");
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            resp = (k == 10);
            #1;
            chk($sformatf("st_k%0d_addr", k),   64'(laddr),  64'hCCC);
            chk($sformatf("st_k%0d_lvalid", k), 64'(lvalid), 64'd1);
            chk($sformatf("st_k%0d_rdy2", k),   64'(rdy2),   64'd0);
        end
        @(negedge clk);
        resp = 1'b0; lk_rdy = 1'b1;
        #1;
        chk("st_rdy2_lk", 64'(rdy2), 64'd0);
        @(negedge clk);
        lk_rdy = 1'b0; resp = 1'b1;
        #1;
        chk("st_rdy2_ws", 64'(rdy2), 64'd0);
        chk("st_addr_ws", 64'(laddr), 64'hCCC);
        @(negedge clk);
        resp = 1'b0;
        #1;
        chk("st_rdy2_idle", 64'(rdy2), 64'd1);
        push_exp(40'hDDD, 4'd8, 1'b0);
        finish_txn("st_p2");

        // Leave port 1 as last serviced so the post-reset tie proves reset restored history.
        sv = '{1'b1, 1'b0, 40'h77, 40'h0, 4'd2, 4'd0, 1'b1};
        do_txn(sv, "pre_rst");

        // Reset while in WAIT_SENT.
        @(negedge clk);
        v1 = 1'b1; a1 = 40'hEEE; i1 = 4'd9;
        #1;
        chk("mr_rdy1", 64'(rdy1), 64'd1);
        push_exp(40'hEEE, 4'd9, 1'b1);
        @(negedge clk);
        v1 = 1'b0; lk_rdy = 1'b1;
        #1;
        check_lookup("mr");
        @(negedge clk);
        lk_rdy = 1'b0;
        #1;
        chk("mr_busy_ws", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0; v1 = 1'b1; v2 = 1'b1;
        #1;
        chk("mr_busy",   64'(busy),   64'd0);
        chk("mr_lvalid", 64'(lvalid), 64'd0);
        chk("mr_rdy1",   64'(rdy1),   64'd0);
        chk("mr_rdy2",   64'(rdy2),   64'd0);
        chk("mr_addr",   64'(laddr),  64'd0);
        chk("mr_tmo",    64'(tmo),    64'd0);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mr_post%0d_tmo", k),  64'(tmo),  64'd0);
            chk($sformatf("mr_post%0d_busy", k), 64'(busy), 64'd0);
        end
        sv = '{1'b1, 1'b1, 40'h10, 40'h20, 4'd1, 4'd2, 1'b1};
        do_txn(sv, "mr_tie");

        chk("nto_never_timeout", 64'(z_tmo_seen), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
